joypad_controller: RTL and testbench

Parametrised successor to the fixed joypad register. It drives the P1/JOYP register at `JOYPAD_ADDR` from eight physical button inputs and adds three behaviours the fixed register lacks: per-button synchronisation, debounce filtering, and decoding through the P14/P15 select lines. It raises a one-cycle joypad interrupt request whenever any visible P10–P13 line falls. It sits on the peripheral bus next to the other MMIO peripherals; the interrupt output feeds the interrupt controller's joypad bit.

---
 rtl/joypad_controller_if.sv | 25 ++
 rtl/joypad_controller.sv | 108 ++++++++++
 tb/tb_joypad_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/joypad_controller_if.sv
// Peripheral bus bundle shared by the MMIO peripherals.
// The CPU side drives address/strobes/write data; a peripheral returns read data.
interface Bus_if;
  logic [15:0] addr;
  logic        read_en;
  logic        write_en;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (
    output addr, read_en, write_en, wdata,
    input  rdata
  );

  modport slave (
    input  addr, read_en, write_en, wdata,
    output rdata
  );

  // Same view as slave, under the name the peripherals use.
  modport Peripheral_side (
    input  addr, read_en, write_en, wdata,
    output rdata
  );
endinterface

// File: rtl/joypad_controller.sv
// P1/JOYP joypad register: synchronises and debounces eight raw buttons,
// decodes them through the P14/P15 select bits and pulses an interrupt
// whenever a visible P10-P13 line falls.
module joypad_controller #(
  parameter logic [15:0] JOYPAD_ADDR     = 16'hFF00,
  parameter int          SYNC_STAGES     = 2,   // must be at least 2
  parameter int          DEBOUNCE_CYCLES = 4    // 0 bypasses the filter
) (
  input  logic           clk,
  input  logic           reset_n,
  Bus_if.Peripheral_side bus,
  input  logic [7:0]     buttons,   // {start, select, b, a, down, up, left, right}
  output logic           joypad_irq
);

  // Counter is kept at least one bit wide so the bypass build still elaborates.
  localparam int             CNT_W   = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES > 0 ? DEBOUNCE_CYCLES - 1 : 0);

  logic [7:0] w_sync;
  logic [7:0] w_deb;
  logic [3:0] w_low;
  logic [1:0] r_sel;
  logic [3:0] r_low_q;
  logic       r_irq;
  logic       w_sel_hit;
  logic       w_wr;
  logic       w_rd;
  logic       w_unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_button
      logic [SYNC_STAGES-1:0] r_chain;
      logic                   r_deb;

      // Synchroniser chain: raw input enters at bit 0, stable copy leaves at the top.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_chain <= '0;
        else          r_chain <= {r_chain[SYNC_STAGES-2:0], buttons[gi]};
      end

      assign w_sync[gi] = r_chain[SYNC_STAGES-1];
      assign w_deb[gi]  = r_deb;

      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        // No filtering: the debounced state simply follows the synchroniser.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) r_deb <= 1'b0;
          else          r_deb <= w_sync[gi];
        end
      end else begin : g_filter
        logic [CNT_W-1:0] r_cnt;

        // Toggle the debounced state once the input has disagreed with it for
        // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
          end else if (w_sync[gi] == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_deb <= ~r_deb;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign w_sel_hit = (bus.addr == JOYPAD_ADDR);
  assign w_wr      = bus.write_en && w_sel_hit;
  assign w_rd      = bus.read_en && w_sel_hit;

  // Only wdata[5:4] is writable; the remaining bits are deliberately dropped.
  assign w_unused_wdata = ^{bus.wdata[7:6], bus.wdata[3:0]};

  // Select bits: 0 enables a group (bit0 = directions, bit1 = actions).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_sel <= 2'b11;
    else if (w_wr) r_sel <= bus.wdata[5:4];
  end

  // Active-low line decode; both groups selected wire-AND together.
  always_comb begin
    w_low = 4'hF;
    if (!r_sel[0]) w_low = w_low & ~w_deb[3:0];
    if (!r_sel[1]) w_low = w_low & ~w_deb[7:4];
  end

  // Remember last cycle's lines and pulse on any 1->0 transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_low_q <= 4'hF;
      r_irq   <= 1'b0;
    end else begin
      r_low_q <= w_low;
      r_irq   <= |(r_low_q & ~w_low);
    end
  end

  assign joypad_irq = r_irq;
  assign bus.rdata  = w_rd ? {2'b11, r_sel, w_low} : 8'hFF;

endmodule

// File: tb/tb_joypad_controller.sv
// Directed bench for joypad_controller (SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4).
module tb_joypad_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] buttons;
  logic       joypad_irq;

  int n_cmp = 0;
  int n_err = 0;
  int irq_cnt = 0;
  int n0;

  Bus_if bus_if ();

  joypad_controller #(
    .JOYPAD_ADDR     (16'hFF00),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .buttons    (buttons),
    .joypad_irq (joypad_irq)
  );

  always #5 clk = ~clk;

  // Each pulse lasts a full cycle, so it is seen at exactly one falling edge.
  always @(negedge clk) if (joypad_irq === 1'b1) irq_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus_if.addr     = a;
    bus_if.wdata    = d;
    bus_if.write_en = 1'b1;
    step();
    bus_if.write_en = 1'b0;
    bus_if.addr     = 16'hFF00;
  endtask

  initial begin
    reset_n         = 1'b0;
    buttons         = 8'h00;
    bus_if.addr     = 16'hFF00;
    bus_if.read_en  = 1'b1;
    bus_if.write_en = 1'b0;
    bus_if.wdata    = 8'h00;
    steps(3);
    check("reset_rdata", bus_if.rdata, 8'hFF);
    check("reset_irq", joypad_irq, 1'b0);

    // All buttons, both groups: bring irq high, then reset mid-cycle.
    reset_n = 1'b1;
    buttons = 8'hFF;
    bus_write(16'hFF00, 8'h00);
    check("sel00_pre_deb", bus_if.rdata, 8'hCF);
    steps(5);
    check("all_pressed", bus_if.rdata, 8'hC0);
    step();
    check("irq_pre_reset", joypad_irq, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_irq_async", joypad_irq, 1'b0);
    check("reset_read_ff00", bus_if.rdata, 8'hFF);
    bus_if.addr = 16'hFF01;
    #1;
    check("reset_read_ff01", bus_if.rdata, 8'hFF);
    bus_if.addr = 16'hFF00;
    buttons = 8'h00;
    steps(2);
    reset_n = 1'b1;
    steps(2);

    // Select directions, press right.
    bus_write(16'hFF00, 8'h20);
    check("sel_dir", bus_if.rdata, 8'hEF);
    buttons = 8'h01;
    n0 = irq_cnt;
    steps(5);
    check("right_edge5", bus_if.rdata, 8'hEF);
    step();
    check("right_edge6", bus_if.rdata, 8'hEE);
    check("irq_not_yet", joypad_irq, 1'b0);
    step();
    check("irq_pulse", joypad_irq, 1'b1);
    step();
    check("irq_done", joypad_irq, 1'b0);
    check("right_irq_cnt", irq_cnt - n0, 1);

    // Release: no interrupt on the rising line.
    buttons = 8'h00;
    n0 = irq_cnt;
    steps(5);
    check("release_edge5", bus_if.rdata, 8'hEE);
    step();
    check("release_edge6", bus_if.rdata, 8'hEF);
    steps(2);
    check("release_no_irq", irq_cnt - n0, 0);

    // Glitch on 'a' for 3 cycles with actions selected.
    bus_write(16'hFF00, 8'h10);
    check("sel_act", bus_if.rdata, 8'hDF);
    n0 = irq_cnt;
    buttons = 8'h10;
    steps(3);
    buttons = 8'h00;
    steps(4);
    check("glitch_mid", bus_if.rdata, 8'hDF);
    steps(6);
    check("glitch_end", bus_if.rdata, 8'hDF);
    check("glitch_no_irq", irq_cnt - n0, 0);

    // Start + down held, then select both groups.
    bus_write(16'hFF00, 8'h30);
    buttons = 8'h88;
    steps(8);
    check("held_desel", bus_if.rdata, 8'hFF);
    n0 = irq_cnt;
    bus_write(16'hFF00, 8'h00);
    check("both_groups", bus_if.rdata, 8'hC7);
    steps(3);
    check("both_irq_cnt", irq_cnt - n0, 1);
    n0 = irq_cnt;
    bus_write(16'hFF00, 8'h30);
    check("deselect", bus_if.rdata, 8'hFF);
    steps(3);
    check("deselect_no_irq", irq_cnt - n0, 0);

    // Write masking and address decode.
    buttons = 8'h00;
    steps(8);
    bus_write(16'hFF01, 8'h00);
    check("wrong_addr_write", bus_if.rdata, 8'hFF);
    bus_write(16'hFF00, 8'hCF);
    check("mask_cf", bus_if.rdata, 8'hCF);
    bus_write(16'hFF00, 8'h30);
    buttons = 8'h10;
    steps(8);
    check("a_held_desel", bus_if.rdata, 8'hFF);
    n0 = irq_cnt;
    bus_write(16'hFF00, 8'h10);
    check("expose_a", bus_if.rdata, 8'hDE);
    steps(3);
    check("expose_irq_cnt", irq_cnt - n0, 1);

    // Reset on the 2nd debounce cycle; full latency again afterwards.
    buttons = 8'h00;
    steps(8);
    bus_write(16'hFF00, 8'h20);
    buttons = 8'h01;
    steps(3);
    reset_n = 1'b0;
    #1;
    check("midcount_reset", bus_if.rdata, 8'hFF);
    step();
    reset_n = 1'b1;
    n0 = irq_cnt;
    bus_write(16'hFF00, 8'h20);
    check("rq_edge1", bus_if.rdata, 8'hEF);
    steps(4);
    check("rq_edge5", bus_if.rdata, 8'hEF);
    step();
    check("rq_edge6", bus_if.rdata, 8'hEE);
    step();
    check("rq_irq", joypad_irq, 1'b1);
    step();
    check("rq_irq_cnt", irq_cnt - n0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
